// File: rtl/cassette_pkg.sv
// cassette_pkg: definitions shared by the cassette record path and the
// playback status decoder.
//   rec_state_e   framer state encoding (also exported on the status port)
//   SDRAM_AW      SDRAM byte address width
//   LEAD_BYTE     leader byte value
//   *_DEF         default half-period limits in clk cycles (21.477 MHz)
package cassette_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4
  } rec_state_e;

  localparam int unsigned SDRAM_AW      = 25;
  localparam logic [7:0]  LEAD_BYTE     = 8'h55;

  localparam int unsigned SHORT_MIN_DEF = 2000;
  localparam int unsigned SHORT_MAX_DEF = 6700;
  localparam int unsigned LONG_MAX_DEF  = 13000;
  localparam int unsigned LEAD_MULT_DEF = 25;

endpackage

// File: rtl/cas_bit_decoder.sv
// cas_bit_decoder: turns the raw FSK cassette-out waveform into bits.
//   clk, rst   clock, asynchronous active-high reset
//   cas_in     raw cassette-out, asynchronous to clk
//   bit_valid  one-cycle strobe: a bit was assembled
//   bit_val    value of that bit (0 = two long halves, 1 = four short halves)
//   silence    level: current half-period exceeds LONG_MAX
module cas_bit_decoder #(
  parameter int unsigned SHORT_MIN = 2000,
  parameter int unsigned SHORT_MAX = 6700,
  parameter int unsigned LONG_MAX  = 13000
) (
  input  logic clk,
  input  logic rst,
  input  logic cas_in,
  output logic bit_valid,
  output logic bit_val,
  output logic silence
);

  localparam logic [15:0] ShortMin = 16'(SHORT_MIN);
  localparam logic [15:0] ShortMax = 16'(SHORT_MAX);
  localparam logic [15:0] LongMax  = 16'(LONG_MAX);

  logic        cas_s1_q, cas_s2_q, cas_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  s_cnt_q, s_cnt_d;
  logic        l_cnt_q, l_cnt_d;
  logic        bit_valid_q, bit_valid_d;
  logic        bit_val_q, bit_val_d;
  logic        edge_det, too_long;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cas_s1_q    <= 1'b0;
      cas_s2_q    <= 1'b0;
      cas_prev_q  <= 1'b0;
      cnt_q       <= '1;    // no edge history: start out as silence
      s_cnt_q     <= '0;
      l_cnt_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_val_q   <= 1'b0;
    end else begin
      cas_s1_q    <= cas_in;
      cas_s2_q    <= cas_s1_q;
      cas_prev_q  <= cas_s2_q;
      cnt_q       <= cnt_d;
      s_cnt_q     <= s_cnt_d;
      l_cnt_q     <= l_cnt_d;
      bit_valid_q <= bit_valid_d;
      bit_val_q   <= bit_val_d;
    end
  end

  always_comb begin
    edge_det    = cas_s2_q ^ cas_prev_q;
    too_long    = cnt_q > LongMax;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    s_cnt_d     = s_cnt_q;
    l_cnt_d     = l_cnt_q;
    bit_valid_d = 1'b0;
    bit_val_d   = bit_val_q;
    if (too_long) begin
      s_cnt_d = '0;
      l_cnt_d = 1'b0;
      if (edge_det) cnt_d = 16'd1;
    end else if (edge_det && cnt_q >= ShortMin) begin
      // counter is 1 in the first cycle of a half, so cnt_q equals its length
      cnt_d = 16'd1;
      if (cnt_q <= ShortMax) begin
        l_cnt_d = 1'b0;
        if (s_cnt_q == 2'd3) begin
          s_cnt_d     = '0;
          bit_valid_d = 1'b1;
          bit_val_d   = 1'b1;
        end else begin
          s_cnt_d = s_cnt_q + 2'd1;
        end
      end else begin
        s_cnt_d = '0;
        if (l_cnt_q) begin
          l_cnt_d     = 1'b0;
          bit_valid_d = 1'b1;
          bit_val_d   = 1'b0;
        end else begin
          l_cnt_d = 1'b1;
        end
      end
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_val   = bit_val_q;
  assign silence   = too_long;

endmodule

// File: rtl/cassette_rec.sv
// cassette_rec: records the SVI-328 cassette-out FSK stream into SDRAM.
//   clk, reset           clock, asynchronous active-high reset
//   record, rewind       level controls, acted on at each edge
//   cas_in               raw cassette-out from the machine
//   sdram_addr/data/wr   write request, held until sdram_ack
//   sdram_ack            one-cycle write acknowledge
//   length               high-water mark of bytes since last rewind
//   overrun              sticky: a byte was dropped while a write was pending
//   status               framer state (cassette_pkg::rec_state_e)
// Build option: CASSETTE_REC_LEAD_COLLAPSE_EN stores one 0x55 byte per
// LEAD_MULT received in a run (undoing playback leader expansion).
module cassette_rec
  import cassette_pkg::*;
#(
  parameter int unsigned SHORT_MIN = SHORT_MIN_DEF,
  parameter int unsigned SHORT_MAX = SHORT_MAX_DEF,
  parameter int unsigned LONG_MAX  = LONG_MAX_DEF,
  parameter int unsigned LEAD_MULT = LEAD_MULT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                record,
  input  logic                rewind,
  input  logic                cas_in,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic [7:0]          sdram_data,
  output logic                sdram_wr,
  input  logic                sdram_ack,
  output logic [SDRAM_AW-1:0] length,
  output logic                overrun,
  output logic [2:0]          status
);

`ifdef CASSETTE_REC_LEAD_COLLAPSE_EN
  localparam bit CollapseEn = 1'b1;
`else
  localparam bit CollapseEn = 1'b0;
`endif
  localparam logic [15:0] LeadLast = 16'(LEAD_MULT - 1);

  logic bit_valid, bit_val, silence;

  cas_bit_decoder #(
    .SHORT_MIN(SHORT_MIN),
    .SHORT_MAX(SHORT_MAX),
    .LONG_MAX (LONG_MAX)
  ) u_dec (
    .clk      (clk),
    .rst      (reset),
    .cas_in   (cas_in),
    .bit_valid(bit_valid),
    .bit_val  (bit_val),
    .silence  (silence)
  );

  rec_state_e          state_q, state_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d, len_q, len_d, addr_inc;
  logic [7:0]          data_q, data_d, byte_val;
  logic                wr_q, wr_d, ovr_q, ovr_d;
  logic [6:0]          shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          ones_q, ones_d;
  logic                in_data_q, in_data_d, stop_q, stop_d;
  logic                rec_prev_q, rew_prev_q;
  logic [15:0]         lead_cnt_q, lead_cnt_d;
  logic                byte_done, keep, rec_rise, rec_fall, rew_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      ovr_q      <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ones_q     <= '0;
      in_data_q  <= 1'b0;
      stop_q     <= 1'b0;
      rec_prev_q <= 1'b0;
      rew_prev_q <= 1'b0;
      lead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      ovr_q      <= ovr_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_q     <= ones_d;
      in_data_q  <= in_data_d;
      stop_q     <= stop_d;
      rec_prev_q <= record;
      rew_prev_q <= rewind;
      lead_cnt_q <= lead_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    data_d     = data_q;
    wr_d       = wr_q;
    ovr_d      = ovr_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    ones_d     = ones_q;
    in_data_d  = in_data_q;
    stop_d     = stop_q;
    lead_cnt_d = lead_cnt_q;
    byte_done  = 1'b0;
    byte_val   = {shift_q, bit_val};
    keep       = !(CollapseEn && byte_val == LEAD_BYTE && lead_cnt_q != '0);
    addr_inc   = addr_q + SDRAM_AW'(1);
    rec_rise   = record & ~rec_prev_q;
    rec_fall   = ~record & rec_prev_q;
    rew_edge   = rewind ^ rew_prev_q;

    // In WRITE the byte framing keeps running via in_data_q so a byte that
    // completes before the ack can be detected and dropped.
    if (bit_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (!bit_val)            ones_d = '0;
          else if (ones_q == 4'd7) begin
            ones_d  = '0;
            state_d = ST_START;
          end else                 ones_d = ones_q + 4'd1;
        end
        ST_START: begin
          if (!bit_val) begin
            state_d   = ST_DATA;
            in_data_d = 1'b1;
            bit_cnt_d = '0;
          end
        end
        ST_DATA, ST_WRITE: begin
          if (in_data_q) begin
            shift_d   = {shift_q[5:0], bit_val};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done = 1'b1;
              in_data_d = 1'b0;
            end
          end else if (!bit_val) begin
            in_data_d = 1'b1;
            bit_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (byte_done) begin
      if (byte_val != LEAD_BYTE)     lead_cnt_d = '0;
      else if (lead_cnt_q == LeadLast) lead_cnt_d = '0;
      else                           lead_cnt_d = lead_cnt_q + 16'd1;
      if (state_q == ST_DATA) begin
        if (keep) begin
          data_d  = byte_val;
          wr_d    = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_START;
        end
      end else if (keep) begin
        ovr_d = 1'b1;
      end
    end

    if (silence) begin
      in_data_d = 1'b0;
      ones_d    = '0;
      if (state_q inside {ST_HUNT, ST_START, ST_DATA}) state_d = ST_HUNT;
    end

    if (state_q == ST_WRITE && sdram_ack) begin
      wr_d   = 1'b0;
      stop_d = 1'b0;
      if (addr_q == '1) begin
        len_d   = '1;
        state_d = ST_IDLE;
      end else begin
        addr_d = addr_inc;
        if (addr_inc > len_q) len_d = addr_inc;
        // resume mid-byte if a start bit arrived while the write was pending
        if (stop_q)         state_d = ST_IDLE;
        else if (in_data_d) state_d = ST_DATA;
        else                state_d = ST_START;
      end
    end

    if (rec_rise) begin
      if (state_q == ST_WRITE && !sdram_ack) begin
        stop_d = 1'b0;
      end else begin
        state_d    = ST_HUNT;
        ones_d     = '0;
        in_data_d  = 1'b0;
        lead_cnt_d = '0;
      end
    end else if (rec_fall) begin
      if (state_q == ST_WRITE && !sdram_ack) begin
        stop_d = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        in_data_d = 1'b0;
      end
    end

    if (rew_edge) begin
      addr_d     = '0;
      len_d      = '0;
      ovr_d      = 1'b0;
      wr_d       = 1'b0;
      stop_d     = 1'b0;
      in_data_d  = 1'b0;
      ones_d     = '0;
      lead_cnt_d = '0;
      state_d    = ST_IDLE;
    end
  end

  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign sdram_wr   = wr_q;
  assign length     = len_q;
  assign overrun    = ovr_q;
  assign status     = state_q;

endmodule

// File: doc/cassette_rec.md
Name: cassette_rec

Overview:
- Recording counterpart of the cassette playback path: decodes the SVI-328 cassette-out FSK waveform into bytes and writes them sequentially into SDRAM.
- 1200 Hz full cycle = bit 0; two 2400 Hz cycles = bit 1.
- Sits between the machine's CAS output pin and the SDRAM arbiter write port.
- Memory image is byte-for-byte what playback reads back.

Parameters:
- SHORT_MIN, 2000: minimum half-period in clk cycles; narrower pulses are glitches and are ignored.
- SHORT_MAX, 6700: half-periods in [SHORT_MIN, SHORT_MAX] are short (2400 Hz half); above this they are long.
- LONG_MAX, 13000: half-periods above this are silence and force a framing reset.
- LEAD_MULT, 25: leader-collapse factor; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock (defaults sized for 21.477 MHz)
- reset  in  1  asynchronous, active-high reset
- record  in  1  level; each edge is significant
- rewind  in  1  level; each edge is significant
- cas_in  in  1  raw cassette-out from the machine, asynchronous to clk
- sdram_addr  out  25  write address
- sdram_data  out  8  write byte
- sdram_wr  out  1  write request, held until acknowledged
- sdram_ack  in  1  one-cycle write acknowledge
- length  out  25  bytes recorded since the last rewind (high-water mark)
- overrun  out  1  sticky: a byte was dropped
- status  out  3  current framer state encoding

Behaviour:
- Reset values: sdram_addr=0, sdram_data=0, sdram_wr=0, length=0, overrun=0, state IDLE (status=0).
- Input conditioning: cas_in passes through a 2-FF synchronizer, then edge detect. Each edge closes a half-period measured by a 16-bit saturating counter.
- Half-period classification:
  - below SHORT_MIN: discarded; counter keeps running, no edge recorded.
  - SHORT_MIN..SHORT_MAX: S.
  - SHORT_MAX+1..LONG_MAX: L.
  - above LONG_MAX (checked continuously, edge not required): silence.
- Bit assembly:
  - 2 consecutive L → bit 0.
  - 4 consecutive S → bit 1.
  - Arrival of the other class before a count completes → counts cleared, partial discarded.
  - Silence → counts cleared, framer returns to HUNT if active.
- Framer states: IDLE=0, HUNT=1, START=2, DATA=3, WRITE=4.
  - IDLE: bits ignored.
  - HUNT: wait for ≥8 consecutive 1 bits, then go to START.
  - START: a 0 bit (start bit) goes to DATA; 1 bits are ignored.
  - DATA: shift 8 bits MSB first. On the 8th bit, latch the byte into sdram_data, assert sdram_wr, go to WRITE.
  - WRITE: hold sdram_wr/addr/data stable until sdram_ack. On the ack cycle: sdram_wr=0, sdram_addr+1, length=max(length, new addr), go to START.
- Decoding continues during WRITE. A byte completing while still in WRITE is dropped and sets overrun; the pending write is unaffected.
- Address saturates at 25'h1FFFFFF. A write at that address still occurs, then the framer goes to IDLE.
- record edge:
  - 0→1: HUNT, keeping sdram_addr (append).
  - 1→0: IDLE. If in WRITE, the pending write completes first, then IDLE.
- rewind edge (any edge): sdram_addr=0, length=0, overrun=0, IDLE, sdram_wr dropped immediately.
- rewind has priority over record in the same cycle.
- reset mid-write: sdram_wr drops asynchronously; the arbiter must tolerate an abandoned request.
- Bit decoder is free-running in every state. Leader and sync detection are purely by bit pattern; no address decoding.

Optional Feature:
- Macro: CASSETTE_REC_LEAD_COLLAPSE_EN.
- With the macro: a run of identical 0x55 bytes is stored as one byte per LEAD_MULT received. A partial final group of ≥1 byte also stores one byte. This reverses the playback leader expansion so the image matches the original file.
- Without the macro: every decoded byte is written.

Decomposition:
- Shared package cassette_pkg holds:
  - state encodings IDLE..WRITE (shared with status decoding in playback),
  - SDRAM_AW=25,
  - LEAD_BYTE=8'h55,
  - default timing constants.
- One sub-module, cas_bit_decoder: synchronizer, half-period counter, classification and bit assembly. Outputs bit_valid (one-cycle), bit_val, silence.
- The framer and SDRAM handshake stay in cassette_rec.

Test Plan:
- Reset, record 0→1, 16 one-bits, start bit, then byte 8'hA5, ack 3 cycles after wr → one write: addr 0, data A5. Then addr=1, length=1, status=START.
- Bytes 0x12, 0x34 back-to-back with ack withheld 20 ms → 0x12 written at addr 0, 0x34 dropped, overrun=1, next ack moves addr to 1.
- Glitch of 500 cycles inside a long half, plus 3 S followed by L → glitch ignored, partial discarded; next clean byte 0x3C decodes correctly.
- Mid-byte silence of 15000 cycles → framer returns to HUNT, no write; record continues normally after a fresh leader.
- rewind edge during WRITE → sdram_wr=0 next cycle, addr=0, length=0, overrun=0, status=IDLE.
- Macro defined, 50×0x55 then 0x7F → writes 0x55, 0x55, 0x7F at addrs 0–2. Macro undefined → 51 writes.
